rv_mem_stage: RTL and testbench

Memory-access pipeline stage of the RV32I core, sitting between execute and write-back. It registers execute-stage results and, for loads and stores, runs a single-outstanding request/acknowledge transaction on the data bus. It generates byte enables and lane-shifted write data from funct3 and address bits, and sign/zero-extends load data. It stalls the pipeline until the bus acknowledges or a timeout fires.

---
 rtl/rv_pkg.sv | 35 +++
 rtl/rv_lsu_align.sv | 60 ++++++
 rtl/rv_mem_stage.sv | 146 ++++++++++++++
 tb/tb_rv_mem_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: load/store funct3 encodings, memory-stage
// FSM states, write-back result-source selectors and the stage-register layout.
package rv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RES_SRC_ALU = 2'd0;
    localparam logic [1:0] RES_SRC_MEM = 2'd1;
    localparam logic [1:0] RES_SRC_PC4 = 2'd2;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_val;
        logic [2:0]  funct3;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  res_src;
        logic [29:0] pc_p4;
    } stage_t;

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational load/store lane logic: byte enables, write-data replication,
// load extraction/extension. Misalignment is only flagged under RV_MEM_STAGE_MISALIGN_EN.
module rv_lsu_align
    import rv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_signed;

    // Lane selection uses the naturally aligned offset, so stray low bits are ignored.
    assign byte_sel  = i_load_word[{i_addr_lo, 3'b000} +: 8];
    assign half_sel  = i_load_word[{i_addr_lo[1], 4'b0000} +: 16];
    assign is_signed = ~i_funct3[2];

    always_comb begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_load_word;
        case (i_funct3[1:0])
            F3_LB[1:0]: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            end
            F3_LH[1:0]: begin
                o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            end
            default: begin
                o_be        = 4'b1111;
                o_wdata     = i_store_data;
                o_load_data = i_load_word;
            end
        endcase
    end

`ifdef RV_MEM_STAGE_MISALIGN_EN
    always_comb begin
        case (i_funct3[1:0])
            F3_LB[1:0]: o_misaligned = 1'b0;
            F3_LH[1:0]: o_misaligned = i_addr_lo[0];
            default:    o_misaligned = |i_addr_lo;
        endcase
    end
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/rv_mem_stage.sv
// RV32I memory stage: stage register plus single-outstanding req/ack data-bus FSM.
// Define RV_MEM_STAGE_MISALIGN_EN to abort misaligned half/word accesses with o_bus_err.
module rv_mem_stage
    import rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rs2_val,
    input  logic [2:0]  i_funct3,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_res_src,
    input  logic [29:0] i_pc_p4,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [29:0] o_dbus_addr,
    output logic [3:0]  o_dbus_be,
    output logic [31:0] o_dbus_wdata,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_stall,
    output logic [31:0] o_alu_result,
    output logic [31:0] o_load_data,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [1:0]  o_res_src,
    output logic [29:0] o_pc_p4,
    output logic        o_bus_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    stage_t           stage_q, stage_d;
    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      load_q, load_d;

    logic        mem_op, misaligned, pending, mis_err, timeout;
    logic [3:0]  be;
    logic [31:0] wdata, load_ext;

    rv_lsu_align u_align (
        .i_funct3     (stage_q.funct3),
        .i_addr_lo    (stage_q.alu_result[1:0]),
        .i_store_data (stage_q.rs2_val),
        .i_load_word  (i_dbus_rdata),
        .o_be         (be),
        .o_wdata      (wdata),
        .o_load_data  (load_ext),
        .o_misaligned (misaligned)
    );

    // done_q marks a captured memory op whose bus access already finished or aborted.
    assign mem_op  = stage_q.mem_read | stage_q.mem_write;
    assign pending = (state_q == IDLE) && mem_op && !done_q && !misaligned;
    assign mis_err = (state_q == IDLE) && mem_op && !done_q && misaligned;
    assign o_stall = (state_q == WAIT_ACK) || pending;
    assign timeout = (TIMEOUT_CYCLES != 0) && ((int'(cnt_q) + 1) == TIMEOUT_CYCLES);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stage_q <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= '0;
        end else begin
            stage_q <= stage_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        stage_d = stage_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = 1'b0;
        load_d  = load_q;
        if (!o_stall) begin
            stage_d = '0;
            done_d  = 1'b0;
            if (!i_flush) begin
                stage_d.alu_result = i_alu_result;
                stage_d.rs2_val    = i_rs2_val;
                stage_d.funct3     = i_funct3;
                stage_d.mem_read   = i_mem_read;
                stage_d.mem_write  = i_mem_write;
                stage_d.reg_write  = i_reg_write;
                stage_d.rd         = i_rd;
                stage_d.res_src    = i_res_src;
                stage_d.pc_p4      = i_pc_p4;
            end
        end
        case (state_q)
            IDLE: begin
                if (pending) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                // Ack takes priority over a timeout firing in the same cycle.
                if (i_dbus_ack) begin
                    state_d = IDLE;
                    if (stage_q.mem_read) load_d = load_ext;
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_dbus_req   = (state_q == WAIT_ACK);
        o_dbus_we    = o_dbus_req & stage_q.mem_write;
        o_dbus_addr  = o_dbus_req ? stage_q.alu_result[31:2] : '0;
        o_dbus_be    = o_dbus_req ? be : '0;
        o_dbus_wdata = o_dbus_req ? wdata : '0;
        o_alu_result = stage_q.alu_result;
        o_load_data  = load_q;
        o_rd         = stage_q.rd;
        o_res_src    = stage_q.res_src;
        o_pc_p4      = stage_q.pc_p4;
        o_bus_err    = err_q | mis_err;
        o_reg_write  = stage_q.reg_write & ~o_stall & ~o_bus_err;
    end

endmodule

// File: tb/tb_rv_mem_stage.sv
// Self-checking bench for rv_mem_stage: directed cases plus randomized ops
// against a transaction-level model of bus lanes, latency and timeout.
module tb_rv_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, mrd, mwr, rw;
    logic [31:0] alu, rs2;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [29:0] pc;
    logic        req, we, ack, stall, o_rw, berr;
    logic [29:0] addr, o_pc;
    logic [3:0]  be;
    logic [31:0] wdata, rdata, o_alu, o_ld;
    logic [4:0]  o_rd;
    logic [1:0]  o_rs;

    int          checks = 0;
    int          errors = 0;
    int          n_ops  = 0;
    logic [31:0] exp_load;

    rv_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(rst), .i_flush(flush),
        .i_alu_result(alu), .i_rs2_val(rs2), .i_funct3(f3),
        .i_mem_read(mrd), .i_mem_write(mwr), .i_reg_write(rw),
        .i_rd(rd), .i_res_src(rs), .i_pc_p4(pc),
        .o_dbus_req(req), .o_dbus_we(we), .o_dbus_addr(addr),
        .o_dbus_be(be), .o_dbus_wdata(wdata),
        .i_dbus_ack(ack), .i_dbus_rdata(rdata),
        .o_stall(stall), .o_alu_result(o_alu), .o_load_data(o_ld),
        .o_reg_write(o_rw), .o_rd(o_rd), .o_res_src(o_rs),
        .o_pc_p4(o_pc), .o_bus_err(berr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        flush = 1'b0; alu = '0; rs2 = '0; f3 = '0; mrd = 1'b0; mwr = 1'b0;
        rw = 1'b0; rd = '0; rs = '0; pc = '0;
    endtask

    function automatic logic [31:0] all_or();
        return 32'(|{req, we, addr, be, wdata, stall, o_alu, o_ld, o_rw, o_rd, o_rs, o_pc, berr});
    endfunction

    // One instruction through the stage; called and returning at a negedge with o_stall low.
    task automatic do_op(input bit ld, input bit st, input logic [2:0] fn, input logic [31:0] a32,
                         input logic [31:0] sd, input bit wr, input logic [4:0] dst, input bit fl,
                         input int ack_at, input logic [31:0] rword);
        int size, lo, al, n, nreq, exp_n, exp_req;
        bit mem, mis, tmo, err;
        logic [31:0] m, v, ebe, ewd;
        logic [1:0]  srcv;
        logic [29:0] pcv;
        srcv = 2'($urandom_range(0, 2));
        pcv  = 30'($urandom);
        size = (fn[1:0] == 2'b00) ? 1 : (fn[1:0] == 2'b01) ? 2 : 4;
        lo   = int'(a32[1:0]);
        mem  = (ld || st) && !fl;
        mis  = 1'b0;
`ifdef RV_MEM_STAGE_MISALIGN_EN
        mis  = mem && ((lo % size) != 0);
`endif
        al      = lo - (lo % size);
        tmo     = mem && !mis && (ack_at > TO);
        err     = mis || tmo;
        exp_req = (!mem || mis) ? 0 : (tmo ? TO : ack_at);
        exp_n   = (!mem || mis) ? 0 : 1 + exp_req;
        ebe     = ((32'h1 << size) - 1) << al;
        ewd     = (size == 1) ? sd[7:0] * 32'h0101_0101 :
                  (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;

        chk("ready", 32'(stall), 32'd0);
        alu = a32; rs2 = sd; f3 = fn; mrd = ld; mwr = st; rw = wr; rd = dst;
        rs = srcv; pc = pcv; flush = fl;
        @(posedge clk); @(negedge clk);

        n = 0; nreq = 0;
        while (stall && n < 20) begin
            n++;
            // Upstream churns while held; none of it may be captured.
            alu = $urandom; rs2 = $urandom; f3 = 3'($urandom); mrd = 1'($urandom);
            mwr = 1'($urandom); rw = 1'($urandom); rd = 5'($urandom); rs = 2'($urandom);
            pc = 30'($urandom); flush = 1'($urandom);
            ack = 1'b0; rdata = $urandom;
            if (req) begin
                nreq++;
                if (nreq == 1) begin
                    chk("bus_addr", 32'(addr), 32'(a32[31:2]));
                    chk("bus_we", 32'(we), 32'(st));
                    chk("bus_be", 32'(be), ebe);
                    if (st) chk("bus_wdata", wdata, ewd);
                end
                if (nreq == ack_at) begin
                    ack = 1'b1;
                    rdata = rword;
                end
            end
            @(posedge clk); @(negedge clk);
            ack = 1'b0;
        end

        if (ld && mem && !mis && !tmo) begin
            v = rword >> (8 * al);
            m = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
            v = v & m;
            if (!fn[2] && size < 4 && v[8 * size - 1]) v = v | ~m;
            exp_load = v;
        end

        chk("stall_cycles", 32'(n), 32'(exp_n));
        chk("req_cycles", 32'(nreq), 32'(exp_req));
        chk("req_done", 32'(req), 32'd0);
        chk("alu_result", o_alu, fl ? 32'd0 : a32);
        chk("rd", 32'(o_rd), fl ? 32'd0 : 32'(dst));
        chk("res_src", 32'(o_rs), fl ? 32'd0 : 32'(srcv));
        chk("pc_p4", 32'(o_pc), fl ? 32'd0 : 32'(pcv));
        chk("reg_write", 32'(o_rw), 32'(wr && !fl && !err));
        chk("bus_err", 32'(berr), 32'(err));
        chk("load_data", o_ld, exp_load);
        drive_idle();
        if (err) begin
            @(posedge clk); @(negedge clk);
            chk("bus_err_pulse", 32'(berr), 32'd0);
        end
        n_ops++;
        $display("op %0d ld=%0b st=%0b f3=%0d addr=%h flush=%0b ack_at=%0d stall=%0d err=%0b",
                 n_ops, ld, st, fn, a32, fl, ack_at, n, err);
    endtask

    int          kind, ack_at;
    logic [2:0]  fn;

    initial begin
        drive_idle();
        ack = 1'b0; rdata = '0; rst = 1'b1; exp_load = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", all_or(), 32'd0);
        rst = 1'b0;

        do_op(0, 0, 3'b000, 32'h1234_5678, 32'd0, 1, 5'd5, 0, 0, 32'd0);
        do_op(0, 1, 3'b000, 32'h0000_0103, 32'hAB, 0, 5'd0, 0, 3, 32'd0);
        do_op(1, 0, 3'b001, 32'h0000_0002, 32'd0, 1, 5'd7, 0, 1, 32'h8001_0000);
        chk("lh_value", o_ld, 32'hFFFF_8001);
        do_op(1, 0, 3'b101, 32'h0000_0002, 32'd0, 1, 5'd7, 0, 2, 32'h8001_0000);
        chk("lhu_value", o_ld, 32'h0000_8001);
        do_op(1, 0, 3'b010, 32'h0000_0200, 32'd0, 1, 5'd9, 0, 99, 32'd0);
        do_op(1, 0, 3'b010, 32'h0000_0102, 32'd0, 1, 5'd3, 0, 1, 32'hCAFE_F00D);
        do_op(0, 1, 3'b010, 32'h0000_0100, 32'h1122_3344, 0, 5'd0, 0, TO, 32'd0);
        do_op(1, 0, 3'b000, 32'h0000_0040, 32'd0, 1, 5'd2, 1, 1, 32'd0);

        // Reset while a load is waiting for its ack.
        alu = 32'h0000_0300; f3 = 3'b010; mrd = 1'b1; rw = 1'b1; rd = 5'd4;
        @(posedge clk); @(negedge clk);
        drive_idle();
        @(posedge clk); @(negedge clk);
        chk("pre_rst_req", 32'(req), 32'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_req", 32'(req), 32'd0);
        chk("mid_rst_outputs", all_or(), 32'd0);
        rst = 1'b0; exp_load = '0;
        $display("op reset during WAIT_ACK");

        for (int i = 0; i < 300; i++) begin
            kind   = $urandom_range(0, 2);
            ack_at = $urandom_range(1, 6);
            case (kind)
                0: fn = 3'($urandom);
                1: begin
                    case ($urandom_range(0, 4))
                        0: fn = 3'b000;
                        1: fn = 3'b001;
                        2: fn = 3'b010;
                        3: fn = 3'b100;
                        default: fn = 3'b101;
                    endcase
                end
                default: fn = 3'($urandom_range(0, 2));
            endcase
            do_op(kind == 1, kind == 2, fn, $urandom, $urandom, 1'($urandom), 5'($urandom),
                  $urandom_range(0, 7) == 0, ack_at, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
